// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Owns the program counter and presents it as the byte address to an
//   instruction memory that answers combinationally. The returned word is
//   captured into the IF/ID pipeline register on the same edge that the PC
//   moves. Normal fetch is sequential (+4). The unit also supports stall,
//   flush and branch/jump redirect. A redirect to a misaligned target traps
//   into a sticky HALT state that only reset can leave.
//
// Ports:
//   Clk           in   1   rising-edge clock
//   Rst           in   1   asynchronous, active-low reset
//   Stall         in   1   hold PC and IF/ID (load-use hazard from ID)
//   Flush         in   1   bubble into IF/ID; PC still advances
//   BranchTaken   in   1   redirect PC to BranchTarget this cycle
//   BranchTarget  in   32  byte address of the redirect target
//   Instruction   in   32  combinational read data from instruction memory
//   Address       out  32  byte address to instruction memory (= PC)
//   IFID_Instr    out  32  registered instruction
//   IFID_PCPlus4  out  32  registered PC+4 belonging to IFID_Instr
//   IFID_Valid    out  1   IFID_Instr is a real fetched instruction
//   Halted        out  1   sticky misaligned-target trap flag
//   FetchCount    out  32  number of valid instructions delivered to IF/ID
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] Instruction,
  output logic [31:0] Address,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        Halted,
  output logic [31:0] FetchCount
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pcplus4_reg, pcplus4_next;
  logic        valid_reg, valid_next;
  logic        halted_reg, halted_next;
  logic [31:0] count_reg, count_next;

  // Wraps modulo 2^32, so 32'hFFFF_FFFC + 4 lands on 0 without any trap.
  logic [31:0] pc_plus4;
  assign pc_plus4 = pc_reg + 32'd4;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_reg   <= BOOT;
      pc_reg      <= RESET_PC;
      instr_reg   <= NOP_INSTR;
      pcplus4_reg <= 32'd0;
      valid_reg   <= 1'b0;
      halted_reg  <= 1'b0;
      count_reg   <= 32'd0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      instr_reg   <= instr_next;
      pcplus4_reg <= pcplus4_next;
      valid_reg   <= valid_next;
      halted_reg  <= halted_next;
      count_reg   <= count_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // Default: everything holds (this is also the Stall behaviour).
    state_next   = state_reg;
    pc_next      = pc_reg;
    instr_next   = instr_reg;
    pcplus4_next = pcplus4_reg;
    valid_next   = valid_reg;
    halted_next  = halted_reg;
    count_next   = count_reg;

    case (state_reg)
      // First edge after reset always fetches RESET_PC; control inputs are
      // not yet honoured so that the pipeline starts from a known word.
      BOOT: begin
        instr_next   = Instruction;
        pcplus4_next = pc_plus4;
        valid_next   = 1'b1;
        pc_next      = pc_plus4;
        count_next   = count_reg + 32'd1;
        state_next   = RUN;
      end

      RUN: begin
        if (BranchTaken) begin
          // A redirect always kills the word currently being fetched,
          // regardless of Stall/Flush.
          instr_next   = NOP_INSTR;
          pcplus4_next = 32'd0;
          valid_next   = 1'b0;
          if (BranchTarget[1:0] == 2'b00) begin
            pc_next = BranchTarget;
          end else begin
            // PC is left on the last good address for post-mortem.
            state_next  = HALT;
            halted_next = 1'b1;
          end
        end else if (Stall) begin
          // Hold everything (defaults).
        end else if (Flush) begin
          pc_next      = pc_plus4;
          instr_next   = NOP_INSTR;
          pcplus4_next = 32'd0;
          valid_next   = 1'b0;
        end else begin
          pc_next      = pc_plus4;
          instr_next   = Instruction;
          pcplus4_next = pc_plus4;
          valid_next   = 1'b1;
          count_next   = count_reg + 32'd1;
        end
      end

      HALT: begin
        // Bubble was already written on entry; rewriting it keeps IF/ID
        // pinned to the bubble even if nothing else changes.
        instr_next   = NOP_INSTR;
        pcplus4_next = 32'd0;
        valid_next   = 1'b0;
        halted_next  = 1'b1;
      end

      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign Address      = pc_reg;
  assign IFID_Instr   = instr_reg;
  assign IFID_PCPlus4 = pcplus4_reg;
  assign IFID_Valid   = valid_reg;
  assign Halted       = halted_reg;
  assign FetchCount   = count_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Directed bench for instruction_fetch_unit. A small combinational memory
// model returns mem[i] = i+1 for word index i (address bits [7:2]).
// Inputs are driven 1 time unit after the rising edge and outputs are
// sampled at the same point, well away from the active edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

  logic        Clk;
  logic        Rst;
  logic        Stall;
  logic        Flush;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] Instruction;
  logic [31:0] Address;
  logic [31:0] IFID_Instr;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic        Halted;
  logic [31:0] FetchCount;

  int tests_run;
  int tests_failed;

  logic [31:0] mem [0:63];

  instruction_fetch_unit dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Stall        (Stall),
    .Flush        (Flush),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Instruction  (Instruction),
    .Address      (Address),
    .IFID_Instr   (IFID_Instr),
    .IFID_PCPlus4 (IFID_PCPlus4),
    .IFID_Valid   (IFID_Valid),
    .Halted       (Halted),
    .FetchCount   (FetchCount)
  );

  // Combinational instruction memory.
  assign Instruction = mem[Address[7:2]];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Advance one rising edge and settle 1 ns past it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Check the whole IF/ID bundle plus PC and counter in one line.
  task automatic check_all(input string tag, input logic [31:0] addr,
                           input logic [31:0] instr, input logic [31:0] pcp4,
                           input logic valid, input logic halted,
                           input logic [31:0] count);
    $display("[TB] %s: Address=0x%08h Instr=0x%08h PCPlus4=0x%08h Valid=%0b Halted=%0b Count=%0d",
             tag, Address, IFID_Instr, IFID_PCPlus4, IFID_Valid, Halted, FetchCount);
    check({tag, ".addr"},   Address,             addr);
    check({tag, ".instr"},  IFID_Instr,          instr);
    check({tag, ".pcp4"},   IFID_PCPlus4,        pcp4);
    check({tag, ".valid"},  {31'd0, IFID_Valid}, {31'd0, valid});
    check({tag, ".halted"}, {31'd0, Halted},     {31'd0, halted});
    check({tag, ".count"},  FetchCount,          count);
  endtask

  // Watchdog: the sequence below is finite, this only guards against a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'(i + 1);

    Rst          = 1'b0;
    Stall        = 1'b0;
    Flush        = 1'b0;
    BranchTaken  = 1'b0;
    BranchTarget = 32'd0;

    // ---------------- Reset values ----------------
    #12;
    check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    Rst = 1'b1;

    // ---------------- T1: BOOT then free run ----------------
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_all($sformatf("t1.cyc%0d", i), 32'(4 * i), 32'(i), 32'(4 * i),
                1'b1, 1'b0, 32'(i));
    end

    // Reset pulse mid-run, then run to PC=0x10.
    #2 Rst = 1'b0;
    #1;
    check_all("t1.rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    Rst = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check_all("t2.pre", 32'h10, 32'd4, 32'h10, 1'b1, 1'b0, 32'd4);

    // ---------------- T2: Stall 3 cycles at PC=0x10 ----------------
    Stall = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_all($sformatf("t2.stall%0d", i), 32'h10, 32'd4, 32'h10,
                1'b1, 1'b0, 32'd4);
    end
    Stall = 1'b0;
    tick();
    check_all("t2.resume", 32'h14, 32'd5, 32'h14, 1'b1, 1'b0, 32'd5);

    // ---------------- T3: Branch 0x40 overriding Stall ----------------
    Stall        = 1'b1;
    BranchTaken  = 1'b1;
    BranchTarget = 32'h40;
    tick();
    check_all("t3.redirect", 32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 32'd5);
    Stall       = 1'b0;
    BranchTaken = 1'b0;
    tick();
    check_all("t3.target", 32'h44, 32'd17, 32'h44, 1'b1, 1'b0, 32'd6);

    // ---------------- T5: Flush at PC=0x8 ----------------
    BranchTaken  = 1'b1;
    BranchTarget = 32'h8;
    tick();
    check_all("t5.goto8", 32'h8, 32'h0, 32'h0, 1'b0, 1'b0, 32'd6);
    BranchTaken = 1'b0;
    Flush       = 1'b1;
    tick();
    check_all("t5.flush", 32'hC, 32'h0, 32'h0, 1'b0, 1'b0, 32'd6);
    Flush = 1'b0;
    tick();
    check_all("t5.after", 32'h10, 32'd4, 32'h10, 1'b1, 1'b0, 32'd7);

    // ---------------- T6: PC wrap at 0xFFFFFFFC ----------------
    BranchTaken  = 1'b1;
    BranchTarget = 32'hFFFF_FFFC;
    tick();
    check_all("t6.top", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 32'd7);
    BranchTaken = 1'b0;
    tick();
    check_all("t6.wrap", 32'h0, 32'd64, 32'h0, 1'b1, 1'b0, 32'd8);
    tick();
    check_all("t6.after", 32'h4, 32'd1, 32'h4, 1'b1, 1'b0, 32'd9);

    // Reset asserted during a stall: clears before the next edge.
    Stall = 1'b1;
    tick();
    check_all("t6.stall", 32'h4, 32'd1, 32'h4, 1'b1, 1'b0, 32'd9);
    #2 Rst = 1'b0;
    #1;
    check_all("t6.rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);

    // BOOT ignores Stall and BranchTaken.
    Rst          = 1'b1;
    Stall        = 1'b0;
    BranchTaken  = 1'b1;
    BranchTarget = 32'h80;
    tick();
    check_all("boot.ignbr", 32'h4, 32'd1, 32'h4, 1'b1, 1'b0, 32'd1);

    // ---------------- T4: misaligned target -> HALT ----------------
    BranchTarget = 32'h42;
    tick();
    check_all("t4.trap", 32'h4, 32'h0, 32'h0, 1'b0, 1'b1, 32'd1);
    BranchTaken = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      check_all($sformatf("t4.hold%0d", i), 32'h4, 32'h0, 32'h0,
                1'b0, 1'b1, 32'd1);
    end
    BranchTaken  = 1'b1;
    BranchTarget = 32'h20;
    tick();
    check_all("t4.nobr", 32'h4, 32'h0, 32'h0, 1'b0, 1'b1, 32'd1);
    BranchTaken = 1'b0;
    #2 Rst = 1'b0;
    #1;
    check_all("t4.rst", 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    Rst = 1'b1;
    tick();
    check_all("t4.reboot", 32'h4, 32'd1, 32'h4, 1'b1, 1'b0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
